// File: rtl/mem_arb_if.sv
// Request/response bundle between two requesters and the memory arbiter.
// The master drives requests; the slave (arbiter) returns ready and the response strobe.
interface mem_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_be;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    // Handshake: a transfer on requester i happens on a rising edge where req_valid[i] and
    // req_ready[i] are both 1; a requester holds valid and its fields stable until then.
    // req_ready depends only on req_valid and the last grant, never on itself.
    // rsp_valid[i] strobes for exactly one cycle, the cycle after requester i's transfer.
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester round-robin arbiter in front of a byte memory with combinational read.
// Define MEM_ARB_BOUNDS_EN to reject accesses with addr > MEM_BYTES-4 (rsp_err set, no write).
module mem_arb #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arb_if.slave    bus,
    output logic [31:0] mem_adrs_rd,
    output logic [31:0] mem_adrs_wr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [3:0]  mem_byt_en
);

    if (MEM_BYTES < 4) begin : g_size_check
        $error("mem_arb: MEM_BYTES must hold at least one 32-bit word");
    end

    logic        r_last;
    logic [1:0]  r_rsp_valid;
    logic [1:0]  r_rsp_err;
    logic [31:0] r_rsp_data;

    logic [1:0]  w_ready;
    logic        w_xfer;
    logic        w_sel;
    logic        w_we;
    logic        w_oob;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    // r_last names the requester granted most recently; the other one wins a tie.
    always_comb begin
        w_ready = 2'b00;
        if (rst_n) begin
            if (bus.req_valid == 2'b11) begin
                w_ready = r_last ? 2'b01 : 2'b10;
            end else begin
                w_ready = bus.req_valid;
            end
        end
    end

    assign w_xfer  = |w_ready;
    assign w_sel   = w_ready[1];
    assign w_we    = w_sel ? bus.req_we[1]          : bus.req_we[0];
    assign w_be    = w_sel ? bus.req_be[7:4]        : bus.req_be[3:0];
    assign w_addr  = w_sel ? bus.req_addr[63:32]    : bus.req_addr[31:0];
    assign w_wdata = w_sel ? bus.req_wdata[63:32]   : bus.req_wdata[31:0];

`ifdef MEM_ARB_BOUNDS_EN
    localparam logic [31:0] LP_LAST_WORD = 32'(MEM_BYTES - 4);
    assign w_oob = w_xfer && (w_addr > LP_LAST_WORD);
`else
    assign w_oob = 1'b0;
`endif

    assign mem_adrs_rd = w_xfer ? w_addr  : 32'h0;
    assign mem_adrs_wr = w_xfer ? w_addr  : 32'h0;
    assign mem_wr_data = w_xfer ? w_wdata : 32'h0;
    assign mem_wr_en   = w_xfer && w_we && !w_oob;
    assign mem_byt_en  = mem_wr_en ? w_be : 4'b0000;

    // Read data is captured at the transfer edge; the memory read port is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 2'b00;
            r_rsp_data  <= 32'h0;
        end else begin
            r_rsp_valid <= w_ready;
            r_rsp_err   <= w_oob ? w_ready : 2'b00;
            r_rsp_data  <= (w_xfer && !w_we && !w_oob) ? mem_rd_data : 32'h0;
            if (w_xfer) begin
                r_last <= w_sel;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: byte memory, behavioural reference checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arb;
    localparam int MEM_BYTES = 128;
`ifdef MEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_adrs_rd;
    logic [31:0] mem_adrs_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_byt_en;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arb_if u_if ();

    mem_arb #(.MEM_BYTES(MEM_BYTES)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.slave),
        .mem_adrs_rd (mem_adrs_rd),
        .mem_adrs_wr (mem_adrs_wr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_byt_en  (mem_byt_en)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- byte memory attached to the DUT ----------------
    logic [7:0] mem [MEM_BYTES];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_BYTES; k++) mem[k] <= 8'h00;
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byt_en[b])
                    mem[(mem_adrs_wr + 32'(b)) % 32'(MEM_BYTES)] <= mem_wr_data[8*b +: 8];
        end
    end

    always_comb begin
        mem_rd_data = 32'h0;
        for (int b = 0; b < 4; b++)
            mem_rd_data[8*b +: 8] = mem[(mem_adrs_rd + 32'(b)) % 32'(MEM_BYTES)];
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [35:0] exp_q[$];          // {rsp_valid, rsp_err, rsp_data} expected next cycle
    int          grant_q[$];        // requester granted, in order
    int          m_last = 1;        // requester granted most recently

    always @(negedge clk) begin : cmp
        logic [35:0] e;
        logic [35:0] nxt;
        logic [1:0]  v;
        logic [1:0]  er;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic        we;
        logic        oob;
        int          g;
        if (!rst_n) begin
            chk("rst_req_ready", 64'(u_if.req_ready), 64'h0);
            chk("rst_rsp_valid", 64'(u_if.rsp_valid), 64'h0);
            chk("rst_rsp_data",  64'(u_if.rsp_data),  64'h0);
            chk("rst_rsp_err",   64'(u_if.rsp_err),   64'h0);
            chk("rst_mem_outs",  {mem_adrs_rd, mem_wr_data}, 64'h0);
            chk("rst_mem_ctl",   {mem_adrs_wr, 27'h0, mem_wr_en, mem_byt_en}, 64'h0);
            m_last = 1;
            exp_q.delete();
            for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = 8'h00;
        end else begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'h0;
            chk("rsp_valid", 64'(u_if.rsp_valid), 64'(e[35:34]));
            chk("rsp_err",   64'(u_if.rsp_err),   64'(e[33:32]));
            chk("rsp_data",  64'(u_if.rsp_data),  64'(e[31:0]));

            v = u_if.req_valid;
            if (v == 2'b11)      g = (m_last == 0) ? 1 : 0;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
            else                 g = -1;
            er = (g < 0) ? 2'b00 : (2'b01 << g);
            chk("req_ready", 64'(u_if.req_ready), 64'(er));

            if (g >= 0) begin
                a   = u_if.req_addr[32*g +: 32];
                wd  = u_if.req_wdata[32*g +: 32];
                be  = u_if.req_be[4*g +: 4];
                we  = u_if.req_we[g];
                oob = BOUNDS && (a > 32'(MEM_BYTES - 4));
                chk("mem_adrs_rd", 64'(mem_adrs_rd), 64'(a));
                chk("mem_adrs_wr", 64'(mem_adrs_wr), 64'(a));
                chk("mem_wr_data", 64'(mem_wr_data), 64'(wd));
                chk("mem_wr_en",   64'(mem_wr_en),   64'(we && !oob));
                chk("mem_byt_en",  64'(mem_byt_en),  64'((we && !oob) ? be : 4'b0000));
                rd = 32'h0;
                if (we && !oob) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[(a + 32'(b)) % 32'(MEM_BYTES)] = wd[8*b +: 8];
                end else if (!we && !oob) begin
                    for (int b = 0; b < 4; b++)
                        rd[8*b +: 8] = ref_mem[(a + 32'(b)) % 32'(MEM_BYTES)];
                end
                nxt = {er, (oob ? er : 2'b00), rd};
                m_last = g;
                grant_q.push_back(g);
            end else begin
                chk("idle_mem_outs", {mem_adrs_rd, mem_wr_data}, 64'h0);
                chk("idle_mem_ctl",  {mem_adrs_wr, 27'h0, mem_wr_en, mem_byt_en}, 64'h0);
                nxt = 36'h0;
            end
            exp_q.push_back(nxt);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 after the response cycle.
    task automatic do_xfer(input int i, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic vld, output logic err, output logic [31:0] rd);
        bit done;
        done = 1'b0;
        u_if.req_we[i]           = we;
        u_if.req_be[4*i +: 4]    = be;
        u_if.req_addr[32*i +: 32]  = a;
        u_if.req_wdata[32*i +: 32] = wd;
        u_if.req_valid[i]        = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (u_if.req_ready[i]) done = 1'b1;
        end
        chk("xfer_accepted", 64'(done), 64'h1);
        @(posedge clk); #1;
        u_if.req_valid[i] = 1'b0;
        @(negedge clk);
        vld = u_if.rsp_valid[i];
        err = u_if.rsp_err[i];
        rd  = u_if.rsp_data;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic        vld;
        logic        err;
        logic [31:0] rd;
        logic [1:0]  acc;
        int          base;
        int          exp_g [6] = '{0, 1, 0, 1, 0, 1};

        rst_n = 1'b0;
        u_if.req_valid = '0;
        u_if.req_we    = '0;
        u_if.req_be    = '0;
        u_if.req_addr  = '0;
        u_if.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // write from r0, read back from r1
        do_xfer(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, vld, err, rd);
        chk("wr10_rsp_valid", 64'(vld), 64'h1);
        chk("wr10_rsp_data",  64'(rd),  64'h0);
        do_xfer(1, 1'b0, 4'b0000, 32'h10, 32'h0, vld, err, rd);
        chk("rd10_rsp_valid", 64'(vld), 64'h1);
        chk("rd10_rsp_data",  64'(rd),  64'hDEADBEEF);

        // byte-enable merge
        do_xfer(0, 1'b1, 4'b1111, 32'h20, 32'h11223344, vld, err, rd);
        do_xfer(0, 1'b1, 4'b0001, 32'h20, 32'h000000AA, vld, err, rd);
        do_xfer(0, 1'b0, 4'b0000, 32'h20, 32'h0, vld, err, rd);
        chk("rd20_merge", 64'(rd), 64'h112233AA);

`ifdef MEM_ARB_BOUNDS_EN
        do_xfer(1, 1'b1, 4'b1111, 32'h7E, 32'hFFFFFFFF, vld, err, rd);
        chk("oob_rsp_err",  64'(err), 64'h1);
        chk("oob_rsp_data", 64'(rd),  64'h0);
        do_xfer(0, 1'b0, 4'b0000, 32'h7C, 32'h0, vld, err, rd);
        chk("oob_mem_kept", 64'(rd),  64'h0);
`endif

        // both requesters continuously valid right after reset
        pulse_reset();
        @(posedge clk); #1;
        base = grant_q.size();
        u_if.req_we = 2'b00;
        u_if.req_addr = {32'h4, 32'h0};
        u_if.req_valid = 2'b11;
        repeat (6) @(posedge clk);
        #1 u_if.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rr_grant_count", 64'(grant_q.size() - base), 64'h6);
        for (int k = 0; k < 6; k++)
            if (base + k < grant_q.size())
                chk($sformatf("rr_grant_%0d", k), 64'(grant_q[base + k]), 64'(exp_g[k]));

        // reset asserted the cycle after a read transfer
        u_if.req_we[0] = 1'b0;
        u_if.req_addr[31:0] = 32'h10;
        u_if.req_valid = 2'b01;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        u_if.req_valid = 2'b00;
        @(negedge clk);
        chk("rst_drop_rsp", 64'(u_if.rsp_valid), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_late_rsp", 64'(u_if.rsp_valid), 64'h0);
        @(posedge clk); #1;
        base = grant_q.size();
        u_if.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 u_if.req_valid = 2'b00;
        chk("rst_first_grant", 64'((grant_q.size() > base) ? grant_q[base] : 9), 64'h0);
        @(posedge clk); #1;

        // randomized traffic; requesters hold each request until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = u_if.req_valid & u_if.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!u_if.req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        u_if.req_we[i]             = 1'($urandom_range(0, 1));
                        u_if.req_be[4*i +: 4]      = 4'($urandom_range(0, 15));
                        u_if.req_wdata[32*i +: 32] = $urandom;
                        if ($urandom_range(0, 1) != 0)
                            u_if.req_addr[32*i +: 32] = $urandom_range(0, 12);
                        else
                            u_if.req_addr[32*i +: 32] =
                                $urandom_range(0, BOUNDS ? MEM_BYTES - 1 : MEM_BYTES - 4);
                        u_if.req_valid[i] = 1'b1;
                    end else begin
                        u_if.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        u_if.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
